fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register; feeds opcodeD to the decode control unit.

---
 rtl/fetch_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; PC drives imem, fetched word latched into decode; halts at END_PC.
// Latency: word at pcF reaches instrD/opcodeD one clock later; a taken branch reaches decode after two.
// Backpressure: stallF holds PC and IF/ID; flushD/branchTakenE bubble IF/ID. Macro FETCH_PERF_CNT_EN builds perf counters.
module fetch_stage #(
    parameter int ADDRWIDTH   = 8,
    parameter int INSTRWIDTH  = 24,
    parameter int OPCODEWIDTH = 4,
    parameter logic [ADDRWIDTH-1:0] RESET_PC = '0,
    parameter logic [ADDRWIDTH-1:0] END_PC   = {ADDRWIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallF,
    input  logic                   flushD,
    input  logic                   branchTakenE,
    input  logic [ADDRWIDTH-1:0]   branchTargetE,
    input  logic [INSTRWIDTH-1:0]  imemDataF,
    output logic [ADDRWIDTH-1:0]   imemAddrF,
    output logic [ADDRWIDTH-1:0]   pcF,
    output logic [INSTRWIDTH-1:0]  instrD,
    output logic [OPCODEWIDTH-1:0] opcodeD,
    output logic [ADDRWIDTH-1:0]   pcPlus1D,
    output logic                   validD,
    output logic                   haltedF,
    output logic [31:0]            fetchCount,
    output logic [31:0]            stallCount
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t               state;
    logic [ADDRWIDTH-1:0] pc_plus1;
    logic                 kill_d;
    logic                 halt_req;
    logic                 load_d;
    logic                 stall_cyc;

    assign imemAddrF = pcF;
    assign opcodeD   = instrD[INSTRWIDTH-1 -: OPCODEWIDTH];
    assign pc_plus1  = pcF + ADDRWIDTH'(1);
    assign kill_d    = branchTakenE | flushD;

    // The end-of-program word is sitting in decode and is not being squashed.
    assign halt_req  = (state == S_RUN) && validD && !kill_d &&
                       ((pcPlus1D - ADDRWIDTH'(1)) == END_PC);
    assign load_d    = (state == S_RUN) && !halt_req && !kill_d && !stallF;
    assign stall_cyc = (state == S_RUN) && stallF && !kill_d;

    // Run/halt FSM with PC and IF/ID register; halting freezes the PC and bubbles decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            pcF      <= RESET_PC;
            instrD   <= '0;
            pcPlus1D <= '0;
            validD   <= 1'b0;
            haltedF  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (halt_req) begin
                        state    <= S_HALT;
                        haltedF  <= 1'b1;
                        instrD   <= '0;
                        pcPlus1D <= '0;
                        validD   <= 1'b0;
                    end else begin
                        // Branch redirect outranks stall for the PC.
                        if (branchTakenE)
                            pcF <= branchTargetE;
                        else if (!stallF)
                            pcF <= pc_plus1;
                        // Squash outranks stall for IF/ID.
                        if (kill_d) begin
                            instrD   <= '0;
                            pcPlus1D <= '0;
                            validD   <= 1'b0;
                        end else if (!stallF) begin
                            instrD   <= imemDataF;
                            pcPlus1D <= pc_plus1;
                            validD   <= 1'b1;
                        end
                    end
                end
                default: begin
                    instrD   <= '0;
                    pcPlus1D <= '0;
                    validD   <= 1'b0;
                    haltedF  <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of valid words loaded into decode.
    always_ff @(posedge clk) begin
        if (rst)
            fetchCount <= '0;
        else if (load_d && (fetchCount != 32'hFFFF_FFFF))
            fetchCount <= fetchCount + 32'd1;
    end

    // Saturating count of run cycles lost to a genuine stall.
    always_ff @(posedge clk) begin
        if (rst)
            stallCount <= '0;
        else if (stall_cyc && (stallCount != 32'hFFFF_FFFF))
            stallCount <= stallCount + 32'd1;
    end
`else
    assign fetchCount = 32'd0;
    assign stallCount = 32'd0;
    logic unused_cnt;
    assign unused_cnt = load_d ^ stall_cyc;
`endif

endmodule
